ahb_req_arbiter: RTL and testbench

AHB_REQ_ARBITER -- requirements
Module: ahb_req_arbiter

---
 rtl/ahb_pkg.sv | 23 ++
 rtl/rr_arb2.sv | 26 ++
 rtl/ahb_req_arbiter.sv | 130 +++++++++++++
 tb/tb_ahb_req_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/ahb_pkg.sv
// ---------------------------------------------------------------------------
// ahb_pkg : shared AHB-lite encodings and arbiter FSM states
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

package ahb_pkg;

  localparam logic [1:0] c_HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] c_HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] c_HBURST_SINGLE = 3'b000;
  localparam logic [3:0] c_HPROT_DATA    = 4'b0011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_ADDR = 2'b01,
    ST_DATA = 2'b10
  } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/rr_arb2.sv
// ---------------------------------------------------------------------------
// rr_arb2 : two-way round-robin selector, favours the requester not granted last
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] gnt,
  output logic       idx
);

  always_comb begin
    idx = 1'b0;
    if (req == 2'b11)
      idx = ~last;
    else if (req == 2'b10)
      idx = 1'b1;
    gnt = (req == 2'b00) ? 2'b00 : (idx ? 2'b10 : 2'b01);
  end

endmodule

`default_nettype wire

// File: rtl/ahb_req_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_req_arbiter : two-requester single-transfer AHB-lite master for an APB bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module ahb_req_arbiter
  import ahb_pkg::*;
#(
  parameter int         TPD     = 1,
  parameter logic [1:0] HSIZE_W = 2'b10
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic [1:0]  REQ,
  input  logic [1:0]  RWRITE,
  input  logic [31:0] RADDR0,
  input  logic [31:0] RADDR1,
  input  logic [31:0] RWDATA0,
  input  logic [31:0] RWDATA1,
  output logic [1:0]  DONE,
  output logic        ERR,
  output logic [31:0] RDATA,
  output logic        HSEL,
  output logic        HWRITE,
  output logic [1:0]  HTRANS,
  output logic [2:0]  HSIZE,
  output logic [2:0]  HBURST,
  output logic        HMASTLOCK,
  output logic [3:0]  HPROT,
  output logic [31:0] HADDR,
  output logic [31:0] HWDATA,
  output logic        HREADYIN,
  input  logic [31:0] HRDATA,
  input  logic        HREADYOUT,
  input  logic        HRESP
);

  arb_state_t  r_state;
  logic        r_last;
  logic        r_hsel;
  logic        r_hwrite;
  logic [1:0]  r_htrans;
  logic [31:0] r_haddr;
  logic [31:0] r_hwdata;
  logic [1:0]  r_done;
  logic        r_err;
  logic [31:0] r_rdata;

  logic [1:0]  w_req;
  logic [1:0]  w_gnt;
  logic        w_idx;

  // A requester still sees REQ high during its own DONE cycle; hide it so
  // the same request is not served twice.
  assign w_req = REQ & ~r_done;

  rr_arb2 u_rr_arb2 (
    .req  (w_req),
    .last (r_last),
    .gnt  (w_gnt),
    .idx  (w_idx)
  );

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state  <= ST_IDLE;
      r_last   <= 1'b1;
      r_hsel   <= 1'b0;
      r_hwrite <= 1'b0;
      r_htrans <= c_HTRANS_IDLE;
      r_haddr  <= '0;
      r_hwdata <= '0;
      r_done   <= '0;
      r_err    <= 1'b0;
      r_rdata  <= '0;
    end else begin
      r_done <= '0;
      case (r_state)
        ST_IDLE: begin
          if (w_gnt != 2'b00) begin
            r_last   <= w_idx;
            r_haddr  <= w_idx ? RADDR1 : RADDR0;
            r_hwdata <= w_idx ? RWDATA1 : RWDATA0;
            r_hwrite <= RWRITE[w_idx];
            r_hsel   <= 1'b1;
            r_htrans <= c_HTRANS_NONSEQ;
            r_state  <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          if (HREADYOUT) begin
            r_hsel   <= 1'b0;
            r_htrans <= c_HTRANS_IDLE;
            r_state  <= ST_DATA;
          end
        end
        ST_DATA: begin
          // First error cycle has HREADYOUT low, so it simply waits here.
          if (HREADYOUT) begin
            r_rdata        <= HRDATA;
            r_err          <= HRESP;
            r_done[r_last] <= 1'b1;
            r_state        <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign DONE  = r_done;
  assign ERR   = r_err;
  assign RDATA = r_rdata;

  assign #TPD HSEL      = r_hsel;
  assign #TPD HWRITE    = r_hwrite;
  assign #TPD HTRANS    = r_htrans;
  assign #TPD HADDR     = r_haddr;
  assign #TPD HWDATA    = r_hwdata;
  assign #TPD HSIZE     = {1'b0, HSIZE_W};
  assign #TPD HBURST    = c_HBURST_SINGLE;
  assign #TPD HMASTLOCK = 1'b0;
  assign #TPD HPROT     = c_HPROT_DATA;
  assign #TPD HREADYIN  = HREADYOUT;

endmodule

`default_nettype wire

// File: tb/tb_ahb_req_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_req_arbiter : directed bench with a behavioural AHB-to-APB bridge
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_ahb_req_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic [1:0]  REQ;
  logic [1:0]  RWRITE;
  logic [31:0] RADDR0, RADDR1, RWDATA0, RWDATA1;
  logic [1:0]  DONE;
  logic        ERR;
  logic [31:0] RDATA;
  logic        HSEL, HWRITE, HMASTLOCK, HREADYIN;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [31:0] HADDR, HWDATA;
  logic [31:0] HRDATA;
  logic        HREADYOUT;
  logic        HRESP;

  int n_chk = 0;
  int n_err = 0;

  ahb_req_arbiter dut (
    .HCLK(HCLK), .HRESET(HRESET), .REQ(REQ), .RWRITE(RWRITE),
    .RADDR0(RADDR0), .RADDR1(RADDR1), .RWDATA0(RWDATA0), .RWDATA1(RWDATA1),
    .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
    .HSEL(HSEL), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
    .HBURST(HBURST), .HMASTLOCK(HMASTLOCK), .HPROT(HPROT), .HADDR(HADDR),
    .HWDATA(HWDATA), .HREADYIN(HREADYIN),
    .HRDATA(HRDATA), .HREADYOUT(HREADYOUT), .HRESP(HRESP)
  );

  always #5 HCLK = ~HCLK;

  // Bridge model: one setup cycle, cfg_wait PREADY-low cycles, optional two-cycle error.
  int          cfg_wait;
  logic [31:0] cfg_prdata;
  logic        cfg_err;
  logic        s_act;
  int          s_cnt;
  logic [31:0] s_addr;
  logic        s_wr;
  logic [31:0] paddr_q, pwdata_q;
  logic [15:0] psel_q;
  logic        pwrite_q;

  always @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      HREADYOUT <= 1'b1;
      HRESP     <= 1'b0;
      HRDATA    <= '0;
      s_act     <= 1'b0;
      s_cnt     <= 0;
    end else if (s_act) begin
      if (HREADYOUT) begin
        s_act    <= 1'b0;
        HRESP    <= 1'b0;
        paddr_q  <= s_addr;
        pwrite_q <= s_wr;
        psel_q   <= 16'(1) << s_addr[27:24];
        if (s_wr) pwdata_q <= HWDATA;
      end else if (s_cnt > 0) begin
        s_cnt <= s_cnt - 1;
      end else if (cfg_err && !HRESP) begin
        HRESP <= 1'b1;
      end else begin
        HREADYOUT <= 1'b1;
        HRDATA    <= cfg_prdata;
      end
    end else if (HSEL && HTRANS == 2'b10 && HREADYIN) begin
      s_act     <= 1'b1;
      s_addr    <= HADDR;
      s_wr      <= HWRITE;
      s_cnt     <= cfg_wait;
      HREADYOUT <= 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(output logic [1:0] d, output int cyc);
    cyc = 0;
    d   = 2'b00;
    while (d == 2'b00 && cyc < 60) begin
      @(negedge HCLK);
      cyc++;
      d = DONE;
    end
  endtask

  logic [1:0] d;
  int         cyc;
  logic [1:0] seen;

  initial begin
    HRESET = 1'b1; REQ = 2'b00; RWRITE = 2'b00;
    RADDR0 = '0; RADDR1 = '0; RWDATA0 = '0; RWDATA1 = '0;
    cfg_wait = 0; cfg_prdata = '0; cfg_err = 1'b0;
    paddr_q = '0; pwdata_q = '0; psel_q = '0; pwrite_q = 1'b0;
    repeat (2) @(negedge HCLK);
    chk("rst_hsel",   32'(HSEL), 32'h0);
    chk("rst_htrans", 32'(HTRANS), 32'h0);
    chk("rst_done",   32'(DONE), 32'h0);
    chk("rst_haddr",  HADDR, 32'h0);
    chk("const_hsize", 32'(HSIZE), 32'h2);
    chk("const_hprot", 32'(HPROT), 32'h3);
    chk("const_hburst_lock", 32'({HBURST, HMASTLOCK}), 32'h0);
    HRESET = 1'b0;
    @(negedge HCLK);

    // Both requesting continuously: strict alternation starting at 0.
    RWRITE = 2'b11; RADDR0 = 32'h0000_0100; RADDR1 = 32'h0000_0200;
    RWDATA0 = 32'h1111_0000; RWDATA1 = 32'h2222_0000;
    REQ = 2'b11;
    for (int i = 0; i < 4; i++) begin
      wait_done(d, cyc);
      chk($sformatf("rr_order%0d", i), 32'(d), (i % 2 == 0) ? 32'h1 : 32'h2);
    end
    REQ = 2'b00;
    @(negedge HCLK);

    // Single write from requester 0, zero-wait bridge.
    RWRITE = 2'b01; RADDR0 = 32'h0100_0004; RWDATA0 = 32'hA5A5_A5A5;
    REQ = 2'b01;
    wait_done(d, cyc);
    REQ = REQ & ~d;
    chk("wr_done", 32'(d), 32'h1);
    chk("wr_latency", 32'(cyc), 32'd4);
    chk("wr_err", 32'(ERR), 32'h0);
    @(negedge HCLK);
    chk("wr_psel1", 32'(psel_q[1]), 32'h1);
    chk("wr_pwdata", pwdata_q, 32'hA5A5_A5A5);
    chk("wr_paddr", paddr_q, 32'h0100_0004);

    // Read from requester 1 with three PREADY-low cycles.
    RWRITE = 2'b00; RADDR1 = 32'h0100_0008;
    cfg_wait = 3; cfg_prdata = 32'h1234_5678;
    REQ = 2'b10;
    wait_done(d, cyc);
    REQ = REQ & ~d;
    chk("rd_done", 32'(d), 32'h2);
    chk("rd_latency", 32'(cyc), 32'd7);
    chk("rd_rdata", RDATA, 32'h1234_5678);
    chk("rd_err", 32'(ERR), 32'h0);
    @(negedge HCLK);
    chk("rd_pwrite", 32'(pwrite_q), 32'h0);

    // Slave error: two-cycle HRESP adds one cycle and reports ERR.
    cfg_wait = 0; cfg_err = 1'b1; cfg_prdata = 32'h0;
    REQ = 2'b01;
    wait_done(d, cyc);
    REQ = REQ & ~d;
    chk("err_done", 32'(d), 32'h1);
    chk("err_latency", 32'(cyc), 32'd5);
    chk("err_flag", 32'(ERR), 32'h1);
    @(negedge HCLK);
    cfg_err = 1'b0; cfg_prdata = 32'hCAFE_F00D;
    REQ = 2'b10;
    wait_done(d, cyc);
    REQ = REQ & ~d;
    chk("post_err_done", 32'(d), 32'h2);
    chk("post_err_flag", 32'(ERR), 32'h0);
    chk("post_err_rdata", RDATA, 32'hCAFE_F00D);
    @(negedge HCLK);

    // Requester 0 drops REQ right after grant; transfer still completes.
    RWRITE = 2'b01; RADDR0 = 32'h0200_0010; RWDATA0 = 32'h5A5A_0F0F;
    REQ = 2'b01;
    @(negedge HCLK);
    REQ = 2'b00;
    wait_done(d, cyc);
    chk("drop_done", 32'(d), 32'h1);
    @(negedge HCLK);
    chk("drop_pwdata", pwdata_q, 32'h5A5A_0F0F);

    // Reset during DATA of a requester-0 transfer.
    cfg_wait = 3;
    RADDR0 = 32'h0300_0000; RWDATA0 = 32'hDEAD_BEEF;
    REQ = 2'b01;
    repeat (3) @(negedge HCLK);
    chk("pre_rst_in_data", 32'({HSEL, HTRANS}), 32'h0);
    HRESET = 1'b1;
    REQ = 2'b00;
    #2;
    chk("mid_rst_hwrite", 32'(HWRITE), 32'h0);
    chk("mid_rst_hwdata", HWDATA, 32'h0);
    chk("mid_rst_haddr", HADDR, 32'h0);
    chk("mid_rst_rdata", RDATA, 32'h0);
    chk("mid_rst_err_done", 32'({ERR, DONE}), 32'h0);
    chk("mid_rst_hsel_htrans", 32'({HSEL, HTRANS}), 32'h0);
    @(negedge HCLK);
    HRESET = 1'b0;
    cfg_wait = 0;
    seen = 2'b00;
    repeat (8) begin
      @(negedge HCLK);
      seen = seen | DONE;
    end
    chk("rst_no_done", 32'(seen), 32'h0);

    // Arbitration restarts with requester 0 favoured, then requester 1 served.
    RWRITE = 2'b00;
    REQ = 2'b11;
    wait_done(d, cyc);
    chk("post_rst_first", 32'(d), 32'h1);
    REQ = 2'b10;
    wait_done(d, cyc);
    REQ = 2'b00;
    chk("post_rst_req10", 32'(d), 32'h2);
    repeat (2) @(negedge HCLK);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
